// File: rtl/mem_pkg.sv
// Shared types and defaults for the lower-level memory responder.
package mem_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_WAIT = 3'd1,
    RD_REQ  = 3'd2,
    RESP    = 3'd3,
    WR_WAIT = 3'd4,
    WR_DONE = 3'd5,
    RECOVER = 3'd6
  } mem_state_t;

  localparam int ADDRESSSIZE_DEF = 32;
  localparam int MEM_DEPTH_DEF   = 1024;

  // The counter only ever holds latency-1, so latency values need $clog2(latency) bits.
  function automatic int cnt_width(input int max_latency);
    if (max_latency <= 2) begin
      return 1;
    end else begin
      return $clog2(max_latency);
    end
  endfunction

endpackage

// File: rtl/mem_array.sv
// Single-port word storage: synchronous write, combinational read, word i powers up holding i.
module mem_array #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 1024
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] idx,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [WIDTH-1:0] words_s [DEPTH];

  for (genvar i = 0; i < DEPTH; i++) begin : g_word
    // Contents survive reset, so the power-up pattern lives on the declaration.
    logic [WIDTH-1:0] word_r = WIDTH'(i);

    // Word update when the shared index selects this location.
    always_ff @(posedge clk) begin
      if (we && (idx == IDX_W'(i))) begin
        word_r <= wdata;
      end
    end

    assign words_s[i] = word_r;
  end

  assign rdata = words_s[idx];

endmodule

// File: rtl/lower_level_memory.sv
// Lower-level memory responder on the shared cache bus: line fills via arbiter grant,
// write-backs with fixed latency, and abort of pending reads when a cache supplies data.
module lower_level_memory
  import mem_pkg::*;
#(
  parameter int ADDRESSSIZE   = ADDRESSSIZE_DEF,
  parameter int MEM_DEPTH     = MEM_DEPTH_DEF,
  parameter int READ_LATENCY  = 4,
  parameter int WRITE_LATENCY = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   BusRd,
  input  logic                   BusRdX,
  input  logic                   Mem_wr,
  input  logic                   Mem_oprn_abort,
  input  logic [ADDRESSSIZE-1:0] Address_Com,
  inout  wire  [ADDRESSSIZE-1:0] Data_Bus_Com,
  input  logic                   Mem_snoop_gnt,
  output logic                   Mem_snoop_req,
  inout  wire                    Data_in_Bus,
  output logic                   Mem_write_done
);

  localparam int IDX_W   = $clog2(MEM_DEPTH);
  localparam int MAX_LAT = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
  localparam int CNT_W   = cnt_width(MAX_LAT);
  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(READ_LATENCY - 1);
  localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WRITE_LATENCY - 1);

  mem_state_t             state_r, state_s;
  logic [CNT_W-1:0]       cnt_r, cnt_s;
  logic [IDX_W-1:0]       idx_r, idx_s;
  logic [ADDRESSSIZE-1:0] wdata_r, wdata_s;
  logic [ADDRESSSIZE-1:0] rd_data_s;
  logic                   snoop_req_r, write_done_r, resp_r;
  logic                   we_s;
  logic                   unused_addr_s;

  assign unused_addr_s = ^Address_Com[ADDRESSSIZE-1:IDX_W];

  // Next-state, counter and latch decode.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    idx_s   = idx_r;
    wdata_s = wdata_r;
    case (state_r)
      IDLE: begin
        if (Mem_wr) begin
          state_s = WR_WAIT;
          cnt_s   = WR_LOAD;
          idx_s   = Address_Com[IDX_W-1:0];
          wdata_s = Data_Bus_Com;
        end else if (BusRd || BusRdX) begin
          state_s = RD_WAIT;
          cnt_s   = RD_LOAD;
          idx_s   = Address_Com[IDX_W-1:0];
        end else begin
          state_s = IDLE;
        end
      end
      RD_WAIT: begin
        if (Mem_oprn_abort) begin
          state_s = RECOVER;
        end else if (cnt_r == '0) begin
          state_s = RD_REQ;
        end else begin
          cnt_s = cnt_r - CNT_W'(1);
        end
      end
      RD_REQ: begin
        if (Mem_oprn_abort) begin
          state_s = RECOVER;
        end else if (Mem_snoop_gnt) begin
          state_s = RESP;
        end else begin
          state_s = RD_REQ;
        end
      end
      RESP:    state_s = RECOVER;
      WR_WAIT: begin
        if (cnt_r == '0) begin
          state_s = WR_DONE;
        end else begin
          cnt_s = cnt_r - CNT_W'(1);
        end
      end
      WR_DONE: state_s = RECOVER;
      RECOVER: state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State, latches and outputs, all registered from the next-state decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      cnt_r        <= '0;
      idx_r        <= '0;
      wdata_r      <= '0;
      snoop_req_r  <= 1'b0;
      write_done_r <= 1'b0;
      resp_r       <= 1'b0;
    end else begin
      state_r      <= state_s;
      cnt_r        <= cnt_s;
      idx_r        <= idx_s;
      wdata_r      <= wdata_s;
      snoop_req_r  <= (state_s == RD_REQ) || (state_s == RESP);
      write_done_r <= (state_s == WR_DONE);
      resp_r       <= (state_s == RESP);
    end
  end

  // The array commits on the edge that leaves WR_DONE, so a reset earlier drops the write.
  assign we_s = (state_r == WR_DONE);

  mem_array #(
    .WIDTH (ADDRESSSIZE),
    .DEPTH (MEM_DEPTH)
  ) u_mem_array (
    .clk   (clk),
    .we    (we_s),
    .idx   (idx_r),
    .wdata (wdata_r),
    .rdata (rd_data_s)
  );

  assign Mem_snoop_req  = snoop_req_r;
  assign Mem_write_done = write_done_r;
  assign Data_in_Bus    = resp_r ? 1'b1 : 1'bz;
  assign Data_Bus_Com   = resp_r ? rd_data_s : {ADDRESSSIZE{1'bz}};

endmodule

// File: tb/tb_lower_level_memory.sv
// Scoreboard bench for lower_level_memory: stimulus queues expected responses, a monitor checks them.
module tb_lower_level_memory;

  typedef struct {
    string       name;
    bit          is_rd;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic        clk, rst_n, bus_rd, bus_rdx, mem_wr, abort, gnt;
  logic [31:0] addr;
  logic        drv_en;
  logic [31:0] drv_data;
  wire  [31:0] data_bus;
  wire         din;
  logic        snoop_req, wdone;

  int   cyc;
  int   n_cmp;
  int   n_bad;
  exp_t exp_q[$];

  assign data_bus = drv_en ? drv_data : 32'hzzzz_zzzz;

  lower_level_memory dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .BusRd          (bus_rd),
    .BusRdX         (bus_rdx),
    .Mem_wr         (mem_wr),
    .Mem_oprn_abort (abort),
    .Address_Com    (addr),
    .Data_Bus_Com   (data_bus),
    .Mem_snoop_gnt  (gnt),
    .Mem_snoop_req  (snoop_req),
    .Data_in_Bus    (din),
    .Mem_write_done (wdone)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s_timeout: got no response, want one within 40 cycles", name);
  endtask

  task automatic push(input string name, input bit is_rd, input logic [31:0] d, input int c);
    exp_t e;
    e.name = name; e.is_rd = is_rd; e.data = d; e.cyc = c;
    exp_q.push_back(e);
  endtask

  task automatic wait_din(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (din === 1'b1) seen = 1'b1;
    end
    if (!seen) timeout(name);
  endtask

  task automatic wait_wdone(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (wdone === 1'b1) seen = 1'b1;
    end
    if (!seen) timeout(name);
  endtask

  task automatic wait_req();
    for (int i = 0; i < 20 && !snoop_req; i++) @(negedge clk);
  endtask

  // Read: response due READ_LATENCY+2 edges after issue, or one edge after a late grant.
  task automatic do_read(input string name, input logic [31:0] a, input bit rdx,
                         input logic [31:0] d, input int stall);
    int c;
    repeat (2) @(negedge clk);
    c = cyc;
    addr = a;
    if (rdx) bus_rdx = 1'b1; else bus_rd = 1'b1;
    if (stall == 0) begin
      push(name, 1'b1, d, c + 6);
    end else begin
      gnt = 1'b0;
      wait_req();
      check({name, "_req_cycle"}, 32'(cyc), 32'(c + 5));
      repeat (stall) begin
        check({name, "_req_held"}, {31'd0, snoop_req & (din !== 1'b1)}, 32'd1);
        @(negedge clk);
      end
      push(name, 1'b1, d, cyc + 1);
      gnt = 1'b1;
    end
    wait_din(name);
    bus_rd = 1'b0; bus_rdx = 1'b0; gnt = 1'b1;
  endtask

  task automatic do_write(input string name, input logic [31:0] a, input logic [31:0] d);
    repeat (2) @(negedge clk);
    push(name, 1'b0, 32'd0, cyc + 3);
    addr = a; mem_wr = 1'b1; drv_en = 1'b1; drv_data = d;
    wait_wdone(name);
    mem_wr = 1'b0; drv_en = 1'b0;
  endtask

  // Monitor: every Data_in_Bus or Mem_write_done cycle must match the head of the queue.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && (din === 1'b1 || wdone === 1'b1)) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_response: got rd=%0b wdone=%0b at cycle %0d, want none",
                   din === 1'b1, wdone, cyc);
        end else begin
          e = exp_q.pop_front();
          if (((din === 1'b1) != e.is_rd) || (cyc != e.cyc) || (e.is_rd && data_bus !== e.data)) begin
            n_bad++;
            $display("FAIL %s: got rd=%0b data=0x%08h cycle=%0d, want rd=%0b data=0x%08h cycle=%0d",
                     e.name, din === 1'b1, data_bus, cyc, e.is_rd, e.data, e.cyc);
          end
        end
      end
    end
  end

  initial begin
    int hits;
    rst_n = 1'b0; bus_rd = 1'b0; bus_rdx = 1'b0; mem_wr = 1'b0; abort = 1'b0;
    gnt = 1'b1; addr = 32'd0; drv_en = 1'b0; drv_data = 32'd0;
    repeat (3) @(negedge clk);
    check("rst_snoop_req", {31'd0, snoop_req}, 32'd0);
    check("rst_write_done", {31'd0, wdone}, 32'd0);
    check("rst_data_in_bus", {31'd0, din === 1'b1}, 32'd0);
    rst_n = 1'b1;

    do_read("rd_0x10", 32'h10, 1'b0, 32'h10, 0);
    do_write("wr_0x20", 32'h20, 32'hDEADBEEF);
    do_read("rdx_0x20", 32'h20, 1'b1, 32'hDEADBEEF, 0);
    do_read("rd_upper_ignored", 32'hFFFF_F005, 1'b0, 32'h5, 0);
    do_read("rd_top_word", 32'h3FF, 1'b0, 32'h3FF, 0);
    do_read("rd_grant_stall", 32'h77, 1'b0, 32'h77, 5);

    // Abort in the second RD_WAIT cycle.
    repeat (2) @(negedge clk);
    addr = 32'h50; bus_rd = 1'b1;
    repeat (2) @(negedge clk);
    abort = 1'b1; bus_rd = 1'b0;
    @(negedge clk);
    abort = 1'b0;
    hits = 0;
    repeat (8) begin
      if (snoop_req) hits++;
      @(negedge clk);
    end
    check("abort_rdwait_no_req", 32'(hits), 32'd0);
    do_read("rd_after_abort", 32'h50, 1'b0, 32'h50, 0);

    // Abort while requesting the bus.
    repeat (2) @(negedge clk);
    gnt = 1'b0; addr = 32'h58; bus_rd = 1'b1;
    wait_req();
    abort = 1'b1; bus_rd = 1'b0;
    @(negedge clk);
    check("abort_rdreq_req_drop", {31'd0, snoop_req}, 32'd0);
    abort = 1'b0; gnt = 1'b1;

    // Reset while holding a bus request.
    repeat (3) @(negedge clk);
    gnt = 1'b0; addr = 32'h60; bus_rd = 1'b1;
    wait_req();
    check("rst_pre_req", {31'd0, snoop_req}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_async_outputs", {30'd0, snoop_req, din === 1'b1}, 32'd0);
    bus_rd = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1; gnt = 1'b1;
    hits = 0;
    repeat (6) begin
      @(negedge clk);
      if (snoop_req) hits++;
    end
    check("post_reset_idle", 32'(hits), 32'd0);

    // Reset during WR_WAIT discards the write.
    repeat (2) @(negedge clk);
    addr = 32'h40; mem_wr = 1'b1; drv_en = 1'b1; drv_data = 32'h12345678;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_wr_done_low", {31'd0, wdone}, 32'd0);
    mem_wr = 1'b0; drv_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    do_read("rd_after_lost_wr", 32'h40, 1'b0, 32'h40, 0);

    // Write and read in the same cycle: write first, held read aliased through 0x430.
    repeat (2) @(negedge clk);
    push("simul_wr", 1'b0, 32'd0, cyc + 3);
    push("simul_rd", 1'b1, 32'hCAFEF00D, cyc + 11);
    addr = 32'h30; mem_wr = 1'b1; bus_rd = 1'b1; drv_en = 1'b1; drv_data = 32'hCAFEF00D;
    wait_wdone("simul_wr");
    mem_wr = 1'b0; drv_en = 1'b0; addr = 32'h430;
    wait_din("simul_rd");
    bus_rd = 1'b0;

    abort = 1'b1;
    do_write("wr_abort_ignored", 32'h3FF, 32'hA5A50001);
    abort = 1'b0;
    do_read("rd_after_abort_wr", 32'h3FF, 1'b1, 32'hA5A50001, 0);

    repeat (5) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
